mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Initiator side of the unified instruction/data memory port in the multi-cycle RISC-V core.
// - Accepts fetch requests and load/store requests from the control FSM and drives MemRead/MemWrite/Address/WriteData.
// - Registers ReadData; performs sub-doubleword load extraction and sign/zero extension.
// - Implements sub-doubleword stores as read-modify-write on the doubleword-wide memory.
// PARAMETERS
// - DATA_W      64  memory/data width; only 64 supported
// - ILEN        32  instruction width returned on fetch
// - DATA_FIRST  1   1: data request wins a simultaneous IDLE request, 0: fetch wins
// PORTS
// - clk           in   1       single clock, all state on posedge
// - reset         in   1       asynchronous, active-high
// - fetch_req     in   1       fetch request; sampled only in IDLE, held until fetch_done
// - fetch_addr    in   64      PC
// - fetch_done    out  1       1-cycle pulse, instr valid
// - instr         out  ILEN    fetched instruction = ReadData[31:0]
// - data_req      in   1       load/store request; sampled only in IDLE, held until data_done
// - data_we       in   1       1 = store, 0 = load
// - data_size     in   2       00 B, 01 H, 10 W, 11 D (funct3[1:0])
// - data_unsigned in   1       loads: zero-extend (funct3[2])
// - data_addr     in   64      byte address
// - data_wdata    in   64      store data, right-aligned
// - data_done     out  1       1-cycle pulse, access complete
// - data_rdata    out  64      extended load data
// - misalign_err  out  1       valid with either done pulse
// - MemRead       out  1       memory selects doubleword index Address>>3 (1) or Address>>2 (0)
// - MemWrite      out  1       memory writes mem[Address>>3] at posedge
// - Address       out  64      memory address
// - WriteData     out  64      memory write data
// - ReadData      in   64      combinational read data
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, including registered instr, data_rdata, misalign_err.
// - Reset mid-operation returns to IDLE immediately. MemWrite is decoded from state, so it drops asynchronously and no partial write occurs.
// - States: IDLE, FETCH, LOAD, ST_RD, ST_WR, DONE.
// - IDLE
//   - Capture request fields.
//   - Both requests pending: arbitrate per DATA_FIRST; loser stays pending.
//   - Misaligned request: go directly to DONE with err=1, rdata/instr=0.
//   - Otherwise: fetch -> FETCH; load -> LOAD; store D -> ST_WR; store B/H/W -> ST_RD.
// - Misaligned means: fetch addr[1:0]!=0; H addr[0]!=0; W addr[1:0]!=0; D addr[2:0]!=0.
// - FETCH: MemRead=0, Address=fetch_addr; capture ReadData[31:0] -> DONE.
// - LOAD
//   - MemRead=1, Address=data_addr.
//   - Extract lane = ReadData >> (addr[2:0]*8); sign- or zero-extend per size; register -> DONE.
// - ST_RD: MemRead=1; register ReadData -> ST_WR.
// - ST_WR
//   - MemWrite=1 for exactly one cycle.
//   - WriteData = (old & ~mask) | ((wdata<<sh) & mask); mask = size-ones << sh, sh = addr[2:0]*8; D writes wdata.
//   - Next state DONE.
// - DONE: pulse fetch_done or data_done (matching the granted request) -> IDLE.
//   - New requests are not sampled in DONE.
// - Latency (request sampled edge 0 to done pulse)
//   - Fetch/load: done high after edge 2.
//   - Store D: done high after edge 2.
//   - Store B/H/W: done high after edge 3.
//   - Misaligned: done high after edge 1.
// - Address/WriteData are 0 and MemRead/MemWrite are 0 in IDLE and DONE.
// STRUCTURE
// - Package mau_pkg
//   - state_t enum.
//   - size_t enum SZ_B/SZ_H/SZ_W/SZ_D.
//   - Function size_mask(size_t).
//   - Function misaligned(addr, size).
// - Sub-module lane_align: combinational extract+extend and store merge; FSM and registers stay in mem_access_unit.
// TESTING (bench memory model: 64-bit array, index Address>>3 if MemRead else Address>>2, sync write)
// 1. Fetch 0x4, mem[1]=0x0000_0000_3280_3603 -> instr=0x32803603, fetch_done after edge 2, MemWrite never 1.
// 2. LB 0x321, mem[100]=0x0000_0000_0000_80FF -> data_rdata=0xFFFF_FFFF_FFFF_FF80; LBU same addr -> 0x80.
// 3. SH 0xBEEF @0x32A, mem[101]=0x1122_3344_5566_7788 -> mem[101]=0x1122_3344_BEEF_7788.
//    One MemRead cycle then exactly one MemWrite cycle; done after edge 3.
// 4. SD 0xDEAD_BEEF_0000_00A5 @0x340 -> single MemWrite cycle, no MemRead.
//    Then LD 0x340 returns same value.
// 5. LW @0x322 -> misalign_err=1 with data_done after edge 1, data_rdata=0, no memory strobes.
// 6. Reset asserted during ST_WR -> MemWrite low same cycle, memory unchanged.
//    fetch_req+data_req together after release -> data done first, then fetch.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit: FSM states, access sizes,
// lane masks and alignment checks.
package mau_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ST_RD,
        S_ST_WR,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_t;

    function automatic logic [63:0] size_mask(input size_t size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Only the low address bits matter; bytes can never be misaligned.
    function automatic logic misaligned(input logic [2:0] addr_lo, input size_t size);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            SZ_D:    return |addr_lo[2:0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane handling: load extraction with sign/zero extension, and the
// read-modify-write merge of a right-aligned store value into the old doubleword.
module lane_align
    import mau_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [63:0] old_data,
    input  logic [63:0] wdata,
    input  logic [2:0]  addr_lo,
    input  size_t       size,
    input  logic        is_unsigned,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    logic [5:0]  sh;
    logic [63:0] lane;
    logic [63:0] mask;

    always_comb begin
        sh   = {addr_lo, 3'b000};
        lane = rdata >> sh;
        mask = size_mask(size) << sh;

        load_data = lane;
        case (size)
            SZ_B: load_data = is_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            SZ_H: load_data = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            SZ_W: load_data = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: load_data = lane;
        endcase

        if (size == SZ_D) begin
            store_data = wdata;
        end else begin
            store_data = (old_data & ~mask) | ((wdata << sh) & mask);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the shared instruction/data memory port: arbitrates fetch and
// load/store requests, sequences the memory strobes and registers the results.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | sample and arbitrate requests, capture request fields
//   S_FETCH  | instruction read (word-indexed), capture instr
//   S_LOAD   | doubleword read, extract and extend lane
//   S_ST_RD  | read old doubleword for a sub-doubleword store
//   S_ST_WR  | single MemWrite cycle with merged data
//   S_DONE   | raise the done pulse for the granted request
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ILEN       = 32,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [DATA_W-1:0] fetch_addr,
    output logic              fetch_done,
    output logic [ILEN-1:0]   instr,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [1:0]        data_size,
    input  logic              data_unsigned,
    input  logic [DATA_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,
    output logic              misalign_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] old_q, old_d;
    size_t             size_q, size_d;
    logic              uns_q, uns_d;
    logic              is_fetch_q, is_fetch_d;
    logic [ILEN-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              fetch_done_q, fetch_done_d;
    logic              data_done_q, data_done_d;

    logic              fetch_ok, data_ok, grant_data, grant_fetch;
    size_t             req_size;
    logic [DATA_W-1:0] load_data, store_data;

    lane_align u_lane_align (
        .rdata       (ReadData),
        .old_data    (old_q),
        .wdata       (wdata_q),
        .addr_lo     (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .store_data  (store_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        old_d        = old_q;
        size_d       = size_q;
        uns_d        = uns_q;
        is_fetch_d   = is_fetch_q;
        instr_d      = instr_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        fetch_done_d = 1'b0;
        data_done_d  = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Address      = '0;
        WriteData    = '0;

        // A request whose done pulse is showing is still held by the requester;
        // ignore it for that one cycle so it is not serviced twice.
        fetch_ok    = fetch_req && !fetch_done_q;
        data_ok     = data_req && !data_done_q;
        grant_data  = data_ok && (DATA_FIRST || !fetch_ok);
        grant_fetch = fetch_ok && !grant_data;
        req_size    = size_t'(data_size);

        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    addr_d     = data_addr;
                    wdata_d    = data_wdata;
                    size_d     = req_size;
                    uns_d      = data_unsigned;
                    is_fetch_d = 1'b0;
                    if (misaligned(data_addr[2:0], req_size)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        err_d = 1'b0;
                        if (!data_we)              state_d = S_LOAD;
                        else if (req_size == SZ_D) state_d = S_ST_WR;
                        else                       state_d = S_ST_RD;
                    end
                end else if (grant_fetch) begin
                    addr_d     = fetch_addr;
                    is_fetch_d = 1'b1;
                    if (misaligned(fetch_addr[2:0], SZ_W)) begin
                        err_d   = 1'b1;
                        instr_d = '0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                Address = addr_q;
                instr_d = ReadData[ILEN-1:0];
                state_d = S_DONE;
            end
            S_LOAD: begin
                MemRead = 1'b1;
                Address = addr_q;
                rdata_d = load_data;
                state_d = S_DONE;
            end
            S_ST_RD: begin
                MemRead = 1'b1;
                Address = addr_q;
                old_d   = ReadData;
                state_d = S_ST_WR;
            end
            S_ST_WR: begin
                MemWrite  = 1'b1;
                Address   = addr_q;
                WriteData = store_data;
                state_d   = S_DONE;
            end
            S_DONE: begin
                fetch_done_d = is_fetch_q;
                data_done_d  = !is_fetch_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            is_fetch_q   <= 1'b0;
            instr_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            old_q        <= old_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            is_fetch_q   <= is_fetch_d;
            instr_q      <= instr_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            fetch_done_q <= fetch_done_d;
            data_done_q  <= data_done_d;
        end
    end

    assign fetch_done   = fetch_done_q;
    assign data_done    = data_done_q;
    assign instr        = instr_q;
    assign data_rdata   = rdata_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized accesses against a
// byte-level memory reference model, and reset/arbitration sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [63:0] fetch_addr = '0;
    logic        fetch_done;
    logic [31:0] instr;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [1:0]  data_size = 2'b00;
    logic        data_unsigned = 1'b0;
    logic [63:0] data_addr = '0;
    logic [63:0] data_wdata = '0;
    logic        data_done;
    logic [63:0] data_rdata;
    logic        misalign_err;
    logic        MemRead, MemWrite;
    logic [63:0] Address, WriteData, ReadData;

    logic [63:0] mem [0:1023];
    logic        tb_we = 1'b0;
    logic [9:0]  tb_idx = '0;
    logic [63:0] tb_val = '0;
    logic [63:0] model_mem [0:63];

    int n_chk = 0;
    int n_fail = 0;

    mem_access_unit #(.DATA_W(64), .ILEN(32), .DATA_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .instr(instr),
        .data_req(data_req), .data_we(data_we), .data_size(data_size),
        .data_unsigned(data_unsigned), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_done(data_done), .data_rdata(data_rdata), .misalign_err(misalign_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    assign ReadData = MemRead ? mem[Address[12:3]] : mem[Address[11:2]];

    always @(posedge clk) begin
        if (MemWrite) mem[Address[12:3]] <= WriteData;
        else if (tb_we) mem[tb_idx] <= tb_val;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [63:0] val);
        tb_we  = 1'b1;
        tb_idx = 10'(idx);
        tb_val = val;
        @(posedge clk); #1;
        tb_we  = 1'b0;
    endtask

    task automatic run_op(input bit is_f, input bit we, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output int lat, output int nrd, output int nwr,
                          output logic [63:0] res, output logic err);
        if (is_f) begin
            fetch_req = 1'b1; fetch_addr = addr;
        end else begin
            data_req = 1'b1; data_we = we; data_size = sz; data_unsigned = uns;
            data_addr = addr; data_wdata = wd;
        end
        lat = -1; nrd = 0; nwr = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            nrd += int'(MemRead);
            nwr += int'(MemWrite);
            if (is_f ? fetch_done : data_done) begin
                lat = k;
                break;
            end
        end
        res = is_f ? {32'd0, instr} : data_rdata;
        err = misalign_err;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reference: assemble/replace bytes individually, then extend arithmetically.
    function automatic logic [63:0] ref_load(input logic [63:0] w, input int off, input int nb, input bit uns);
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) v |= 64'(w[(off + i) * 8 +: 8]) << (8 * i);
        if (!uns && nb < 8 && v[8 * nb - 1]) v |= ~64'd0 << (8 * nb);
        return v;
    endfunction

    function automatic logic [63:0] ref_store(input logic [63:0] w, input int off, input int nb, input logic [63:0] wd);
        for (int i = 0; i < nb; i++) w[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
        return w;
    endfunction

    typedef struct {
        bit          is_f;
        bit          we;
        logic [1:0]  sz;
        bit          uns;
        logic [63:0] addr;
        logic [63:0] wd;
        bit          pre;
        int          pidx;
        logic [63:0] pval;
        logic [63:0] exp_res;
        bit          exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        bit          chkm;
        int          midx;
        logic [63:0] exp_mem;
    } vec_t;

    vec_t vt [12];

    initial begin
        int lat, nrd, nwr, dcyc, fcyc;
        logic [63:0] res, dres, fres;
        logic err;

        vt[0]  = '{1, 0, 2'd2, 0, 64'h4,   64'h0, 1, 1,   64'h0000_0000_3280_3603, 64'h3280_3603, 0, 2, 0, 0, 0, 0, 64'h0};
        vt[1]  = '{0, 0, 2'd0, 0, 64'h321, 64'h0, 1, 100, 64'h0000_0000_0000_80FF, 64'hFFFF_FFFF_FFFF_FF80, 0, 2, 1, 0, 0, 0, 64'h0};
        vt[2]  = '{0, 0, 2'd0, 1, 64'h321, 64'h0, 0, 0,   64'h0, 64'h0000_0000_0000_0080, 0, 2, 1, 0, 0, 0, 64'h0};
        vt[3]  = '{0, 0, 2'd1, 0, 64'h320, 64'h0, 0, 0,   64'h0, 64'hFFFF_FFFF_FFFF_80FF, 0, 2, 1, 0, 0, 0, 64'h0};
        vt[4]  = '{0, 1, 2'd1, 0, 64'h32A, 64'hBEEF, 1, 101, 64'h1122_3344_5566_7788, 64'h0, 0, 3, 1, 1, 1, 101, 64'h1122_3344_BEEF_7788};
        vt[5]  = '{0, 1, 2'd3, 0, 64'h340, 64'hDEAD_BEEF_0000_00A5, 1, 104, 64'h0, 64'h0, 0, 2, 0, 1, 1, 104, 64'hDEAD_BEEF_0000_00A5};
        vt[6]  = '{0, 0, 2'd3, 0, 64'h340, 64'h0, 0, 0,   64'h0, 64'hDEAD_BEEF_0000_00A5, 0, 2, 1, 0, 0, 0, 64'h0};
        vt[7]  = '{0, 0, 2'd2, 0, 64'h322, 64'h0, 0, 0,   64'h0, 64'h0, 1, 1, 0, 0, 0, 0, 64'h0};
        vt[8]  = '{0, 0, 2'd2, 1, 64'h344, 64'h0, 0, 0,   64'h0, 64'h0000_0000_DEAD_BEEF, 0, 2, 1, 0, 0, 0, 64'h0};
        vt[9]  = '{0, 0, 2'd2, 0, 64'h344, 64'h0, 0, 0,   64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 2, 1, 0, 0, 0, 64'h0};
        vt[10] = '{1, 0, 2'd2, 0, 64'h6,   64'h0, 0, 0,   64'h0, 64'h0, 1, 1, 0, 0, 0, 0, 64'h0};
        vt[11] = '{0, 1, 2'd0, 0, 64'h347, 64'h12, 0, 0,  64'h0, 64'h0, 0, 3, 1, 1, 1, 104, 64'h12AD_BEEF_0000_00A5};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_done", 64'(fetch_done), 64'd0);
        chk("rst_data_done", 64'(data_done), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_rdata", data_rdata, 64'd0);
        chk("rst_err", 64'(misalign_err), 64'd0);
        chk("rst_memread", 64'(MemRead), 64'd0);
        chk("rst_memwrite", 64'(MemWrite), 64'd0);
        chk("rst_address", Address, 64'd0);
        chk("rst_writedata", WriteData, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            if (vt[i].pre) preload(vt[i].pidx, vt[i].pval);
            run_op(vt[i].is_f, vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd,
                   lat, nrd, nwr, res, err);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("v%0d_memread_cycles", i), 64'(nrd), 64'(vt[i].exp_rd));
            chk($sformatf("v%0d_memwrite_cycles", i), 64'(nwr), 64'(vt[i].exp_wr));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vt[i].exp_err));
            if (!vt[i].we) chk($sformatf("v%0d_result", i), res, vt[i].exp_res);
            if (vt[i].chkm) chk($sformatf("v%0d_mem", i), mem[vt[i].midx], vt[i].exp_mem);
        end

        for (int i = 0; i < 64; i++) begin
            model_mem[i] = {$urandom, $urandom};
            preload(i, model_mem[i]);
        end

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                int a;
                bit mis;
                a = int'($urandom_range(0, 63)) * 4;
                if ($urandom_range(0, 2) == 0) a += int'($urandom_range(1, 3));
                mis = (a % 4) != 0;
                run_op(1'b1, 1'b0, 2'd2, 1'b0, 64'(a), 64'd0, lat, nrd, nwr, res, err);
                chk($sformatf("r%0d_fetch_latency", t), 64'(lat), mis ? 64'd1 : 64'd2);
                chk($sformatf("r%0d_fetch_err", t), 64'(err), 64'(mis));
                chk($sformatf("r%0d_fetch_instr", t), res, mis ? 64'd0 : {32'd0, model_mem[a / 4][31:0]});
                chk($sformatf("r%0d_fetch_writes", t), 64'(nwr), 64'd0);
            end else begin
                int sz, nb, idx, off;
                bit we, uns, mis;
                logic [63:0] wd;
                sz  = int'($urandom_range(0, 3));
                nb  = 1 << sz;
                idx = int'($urandom_range(0, 63));
                off = int'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) off = off - (off % nb);
                we  = 1'($urandom_range(0, 1));
                uns = 1'($urandom_range(0, 1));
                wd  = {$urandom, $urandom};
                mis = (off % nb) != 0;
                run_op(1'b0, we, 2'(sz), uns, 64'(idx * 8 + off), wd, lat, nrd, nwr, res, err);
                chk($sformatf("r%0d_latency", t), 64'(lat),
                    mis ? 64'd1 : ((we && nb < 8) ? 64'd3 : 64'd2));
                chk($sformatf("r%0d_err", t), 64'(err), 64'(mis));
                chk($sformatf("r%0d_writes", t), 64'(nwr), 64'(we && !mis));
                if (!we) chk($sformatf("r%0d_rdata", t), res,
                             mis ? 64'd0 : ref_load(model_mem[idx], off, nb, uns));
                if (we && !mis) begin
                    model_mem[idx] = ref_store(model_mem[idx], off, nb, wd);
                    chk($sformatf("r%0d_mem", t), mem[idx], model_mem[idx]);
                end
            end
        end

        preload(102, 64'hA1A2_A3A4_A5A6_A7A8);
        data_req = 1'b1; data_we = 1'b1; data_size = 2'd0; data_unsigned = 1'b0;
        data_addr = 64'h330; data_wdata = 64'h5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("st_wr_memwrite_high", 64'(MemWrite), 64'd1);
        reset = 1'b1;
        data_req = 1'b0;
        #1;
        chk("rst_memwrite_drop", 64'(MemWrite), 64'd0);
        chk("rst_address_drop", Address, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mem_unchanged", mem[102], 64'hA1A2_A3A4_A5A6_A7A8);
        @(posedge clk); #1;

        fetch_req = 1'b1; fetch_addr = 64'h8;
        data_req = 1'b1; data_we = 1'b0; data_size = 2'd3; data_addr = 64'h330;
        dcyc = -1; fcyc = -1; dres = '0; fres = '0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (data_done && dcyc < 0) begin
                dcyc = k; dres = data_rdata; data_req = 1'b0;
            end
            if (fetch_done && fcyc < 0) begin
                fcyc = k; fres = {32'd0, instr}; fetch_req = 1'b0;
            end
            if (dcyc >= 0 && fcyc >= 0) break;
        end
        fetch_req = 1'b0; data_req = 1'b0;
        chk("arb_data_latency", 64'(dcyc), 64'd2);
        chk("arb_data_value", dres, 64'hA1A2_A3A4_A5A6_A7A8);
        chk("arb_fetch_after_data", 64'(fcyc > dcyc), 64'd1);
        chk("arb_fetch_instr", fres, {32'd0, model_mem[2][31:0]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
